// File: rtl/clk_div_pkg.sv
// Shared constants and types for the multi-speed clock divider.
package clk_div_pkg;

    localparam int SPEED_W = 2;

    localparam int HALF0_DEF = 25_000_000;
    localparam int HALF1_DEF = 2_500_000;
    localparam int HALF2_DEF = 250_000;
    localparam int HALF3_DEF = 25_000;

    typedef logic [SPEED_W-1:0] speed_t;

    // A half-period below one cycle cannot be generated; run those at H = 1.
    function automatic int clamp_half(input int half);
        return (half < 1) ? 1 : half;
    endfunction

endpackage

// File: rtl/clk_div_multi_sync2.sv
// Generic two-flop synchroniser with synchronous active-high reset to zero.
module sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/clk_div_multi.sv
// Multi-speed 50%-duty clock divider with tick enable and run/hold control.
// Define CLK_DIV_SPEED_SYNC_EN to pass speed through a 2-flop synchroniser.
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int CNT_W = 26,
    parameter int HALF0 = HALF0_DEF,
    parameter int HALF1 = HALF1_DEF,
    parameter int HALF2 = HALF2_DEF,
    parameter int HALF3 = HALF3_DEF
) (
    input  logic               clk50m,
    input  logic               rst,
    input  logic               en,
    input  logic [SPEED_W-1:0] speed,
    output logic               clkout,
    output logic               tick,
    output logic [SPEED_W-1:0] speed_act
);

    localparam logic [CNT_W-1:0] TERM0 = CNT_W'(clamp_half(HALF0) - 1);
    localparam logic [CNT_W-1:0] TERM1 = CNT_W'(clamp_half(HALF1) - 1);
    localparam logic [CNT_W-1:0] TERM2 = CNT_W'(clamp_half(HALF2) - 1);
    localparam logic [CNT_W-1:0] TERM3 = CNT_W'(clamp_half(HALF3) - 1);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] term_cnt;
    logic             terminal;
    speed_t           speed_use;

`ifdef CLK_DIV_SPEED_SYNC_EN
    sync2 #(.WIDTH(SPEED_W)) u_speed_sync (
        .clk (clk50m),
        .rst (rst),
        .d   (speed),
        .q   (speed_use)
    );
`else
    assign speed_use = speed;
`endif

    always_comb begin
        term_cnt = TERM0;
        case (speed_act)
            2'd0:    term_cnt = TERM0;
            2'd1:    term_cnt = TERM1;
            2'd2:    term_cnt = TERM2;
            default: term_cnt = TERM3;
        endcase
    end

    assign terminal = (cnt == term_cnt);

    // speed_act only reloads on the 1->0 toggle, so a new ratio always
    // starts with a full low phase and the counter never overshoots.
    always_ff @(posedge clk50m) begin
        if (rst) begin
            cnt       <= '0;
            clkout    <= 1'b0;
            tick      <= 1'b0;
            speed_act <= '0;
        end else if (en) begin
            if (terminal) begin
                cnt    <= '0;
                clkout <= ~clkout;
                tick   <= ~clkout;
                if (clkout) begin
                    speed_act <= speed_use;
                end
            end else begin
                cnt  <= cnt + 1'b1;
                tick <= 1'b0;
            end
        end else begin
            tick <= 1'b0;
        end
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// Scoreboard bench for clk_div_multi: directed scenarios then random rst/en/speed.
module tb_clk_div_multi;

    logic       clk50m = 1'b0;
    logic       rst    = 1'b1;
    logic       en     = 1'b0;
    logic [1:0] speed  = 2'd0;
    logic       clkout;
    logic       tick;
    logic [1:0] speed_act;

    clk_div_multi #(
        .CNT_W (4),
        .HALF0 (2),
        .HALF1 (3),
        .HALF2 (5),
        .HALF3 (1)
    ) dut (
        .clk50m    (clk50m),
        .rst       (rst),
        .en        (en),
        .speed     (speed),
        .clkout    (clkout),
        .tick      (tick),
        .speed_act (speed_act)
    );

    always #10 clk50m = ~clk50m;

    typedef struct packed {
        logic       clk;
        logic       tck;
        logic [1:0] act;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   done   = 0;

    // Reference model: position within the current half-phase, phase level,
    // the ratio in force for this period, and pending synchroniser stages.
    int half_tab[4] = '{2, 3, 5, 1};
    int m_pos = 0, m_lvl = 0, m_tick = 0, m_act = 0;
    int m_s1 = 0, m_s2 = 0;

    task automatic step(input bit r, input bit e, input int s);
        int   eff;
        exp_t x;
        @(negedge clk50m);
        rst   = r;
        en    = e;
        speed = 2'(s);
        if (r) begin
            m_pos = 0; m_lvl = 0; m_tick = 0; m_act = 0; m_s1 = 0; m_s2 = 0;
        end else begin
`ifdef CLK_DIV_SPEED_SYNC_EN
            eff  = m_s2;
            m_s2 = m_s1;
            m_s1 = s;
`else
            eff = s;
`endif
            if (!e) begin
                m_tick = 0;
            end else if (m_pos + 1 >= half_tab[m_act]) begin
                m_pos = 0;
                if (m_lvl == 1) m_act = eff;
                m_lvl  = 1 - m_lvl;
                m_tick = m_lvl;
            end else begin
                m_pos  = m_pos + 1;
                m_tick = 0;
            end
        end
        x.clk = m_lvl[0];
        x.tck = m_tick[0];
        x.act = 2'(m_act);
        exp_q.push_back(x);
    endtask

    // Monitor: one expected entry per clock edge, compared just after it.
    initial begin
        exp_t x;
        while (!done || exp_q.size() > 0) begin
            @(posedge clk50m);
            #1;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                checks += 3;
                if (clkout !== x.clk) begin
                    errors++;
                    $display("FAIL clkout t=%0t got %b want %b", $time, clkout, x.clk);
                end
                if (tick !== x.tck) begin
                    errors++;
                    $display("FAIL tick t=%0t got %b want %b", $time, tick, x.tck);
                end
                if (speed_act !== x.act) begin
                    errors++;
                    $display("FAIL speed_act t=%0t got %0d want %0d", $time, speed_act, x.act);
                end
            end
        end
    end

    initial begin
        int r_cnt;
        int tick_seen;
        // Reset, then speed 0 (H=2)
        step(1, 0, 0);
        step(1, 0, 0);
        for (int i = 0; i < 14; i++) step(0, 1, 0);
        // Speed 3 (H=1), applied at the next 1->0 toggle
        for (int i = 0; i < 10; i++) step(0, 1, 3);
        // Change to speed 2 mid-period, several requests in one period
        step(0, 1, 1);
        step(0, 1, 2);
        for (int i = 0; i < 24; i++) step(0, 1, 2);
        // en drop for 4 cycles mid-phase
        step(0, 1, 2);
        step(0, 1, 2);
        for (int i = 0; i < 4; i++) step(0, 0, 2);
        for (int i = 0; i < 12; i++) step(0, 1, 2);
        // Reset mid-operation for one cycle, then scenario 1 again
        step(0, 1, 0);
        step(1, 1, 0);
        for (int i = 0; i < 12; i++) step(0, 1, 0);
        // Single-cycle speed glitches
        for (int i = 0; i < 40; i++) step(0, 1, (i % 7 == 3) ? 1 : 0);

        for (int i = 0; i < 3000; i++) begin
            r_cnt = $urandom_range(0, 99);
            step(r_cnt == 0, $urandom_range(0, 5) != 0,
                 ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 3)) : int'(speed));
        end

        // Spot check of scenario 1 against closed form: ticks at 2, 6, 10 after reset
        step(1, 0, 0);
        tick_seen = 0;
        for (int k = 0; k < 12; k++) begin
            step(0, 1, 0);
            @(posedge clk50m);
            #1;
            checks++;
            if (tick !== ((k + 1) % 4 == 2)) begin
                errors++;
                $display("FAIL scen1_tick k=%0d got %b want %b", k + 1, tick, ((k + 1) % 4 == 2));
            end
            if (tick) tick_seen++;
        end
        checks++;
        if (tick_seen != 3) begin
            errors++;
            $display("FAIL scen1_tick_count got %0d want 3", tick_seen);
        end

        @(posedge clk50m);
        #3;
        done = 1;
        @(posedge clk50m);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain got %0d want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
